// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: reset vector, IF->ID bus layout, ADEF code.
// Imported by the interface, the hold buffer and the IF stage top.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam int          FS_TO_DS_BUS_WD  = 65;
  localparam logic [5:0]  ECODE_ADEF       = 6'h08;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fs_to_ds_t;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// SRAM-like instruction bus: one request per req&addr_ok, in-order data_ok responses.
// The fetch stage is the master; the memory (or bench) is the slave.
interface if_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output addr_ok,
    output data_ok,
    output rdata
  );

endinterface

// File: rtl/if_stage_fetch_inst_buf.sv
// One-entry hold buffer for an instruction returned while decode is stalled.
// Clear wins over load so a redirect always empties it.
module fetch_inst_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic [31:0] o_data
);

  logic        r_valid;
  logic [31:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/if_stage.sv
// Pre-IF + IF fetch stage: PC generation, single-outstanding instruction requests,
// redirect handling with stale-response discard, and the IF->ID valid/allowin handshake.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_adef,
  if_stage_if.master  inst_sram
);

  logic [31:0] r_pf_pc;
  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_fs_adef;
  logic        r_discard;
  logic        r_adef_lock;

  logic        w_cancel;
  logic [31:0] w_redirect_target;
  logic        w_readygo;
  logic        w_fs_allowin;
  logic        w_pf_ok;
  logic        w_issue;
  logic        w_adef_go;
  logic        w_leave;
  logic        w_buf_load;
  logic        w_buf_clear;
  logic        w_buf_valid;
  logic [31:0] w_buf_inst;
  fs_to_ds_t   w_fs_to_ds;

  assign w_cancel          = flush | br_taken;
  assign w_redirect_target = flush ? flush_target : br_target;

  // IF handshake
  assign w_readygo      = r_fs_adef | w_buf_valid | (inst_sram.data_ok & ~r_discard);
  assign w_fs_allowin   = ~r_fs_valid | (w_readygo & ds_allowin);
  assign fs_to_ds_valid = r_fs_valid & w_readygo & ~w_cancel;
  assign w_leave        = fs_to_ds_valid & ds_allowin;

  // Pre-IF may act this cycle; the alignment check decides request vs. ADEF entry
  assign w_pf_ok   = w_fs_allowin & ~w_cancel & ~r_discard & ~r_adef_lock & ~rst;
  assign inst_sram.req  = w_pf_ok & pc_aligned(r_pf_pc);
  assign inst_sram.addr = r_pf_pc;
  assign w_issue   = inst_sram.req & inst_sram.addr_ok;
  assign w_adef_go = w_pf_ok & ~pc_aligned(r_pf_pc);

  assign w_buf_load  = r_fs_valid & inst_sram.data_ok & ~r_discard & ~ds_allowin & ~w_cancel;
  assign w_buf_clear = w_cancel | w_issue | w_adef_go | w_leave;

  fetch_inst_buf u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (inst_sram.rdata),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pf_pc     <= RESET_PC;
      r_fs_valid  <= 1'b0;
      r_fs_pc     <= 32'h0;
      r_fs_adef   <= 1'b0;
      r_discard   <= 1'b0;
      r_adef_lock <= 1'b0;
    end else if (w_cancel) begin
      r_pf_pc     <= w_redirect_target;
      r_fs_valid  <= 1'b0;
      r_fs_adef   <= 1'b0;
      r_adef_lock <= 1'b0;
      // A response still in flight for the cancelled fetch must be swallowed later
      if (r_discard)
        r_discard <= ~inst_sram.data_ok;
      else
        r_discard <= r_fs_valid & ~r_fs_adef & ~w_buf_valid & ~inst_sram.data_ok;
    end else begin
      if (r_discard && inst_sram.data_ok)
        r_discard <= 1'b0;
      if (w_issue) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= r_pf_pc;
        r_fs_adef  <= 1'b0;
        r_pf_pc    <= r_pf_pc + 32'd4;
      end else if (w_adef_go) begin
        r_fs_valid  <= 1'b1;
        r_fs_pc     <= r_pf_pc;
        r_fs_adef   <= 1'b1;
        r_adef_lock <= 1'b1;
      end else if (w_leave) begin
        r_fs_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_fs_to_ds.pc   = r_fs_pc;
    w_fs_to_ds.adef = r_fs_adef;
    if (r_fs_adef)
      w_fs_to_ds.inst = 32'h0;
    else if (w_buf_valid)
      w_fs_to_ds.inst = w_buf_inst;
    else
      w_fs_to_ds.inst = inst_sram.rdata;
  end

  assign fs_to_ds_pc   = w_fs_to_ds.pc;
  assign fs_to_ds_inst = w_fs_to_ds.inst;
  assign fs_to_ds_adef = w_fs_to_ds.adef;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage (pre-IF + IF) that sits directly upstream of decode. It generates the PC and issues one instruction request at a time on the instruction SRAM-like bus. It applies branch and flush redirects, drops responses that belong to cancelled fetches, and holds a returned instruction while decode is stalled. It drives the ID valid/allowin handshake.

Parameters:
RESET_PC, 32'h1c00_0000, first fetch address after reset.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ds_allowin  in  1  decode can accept this cycle
br_taken  in  1  branch redirect from ID (cancels IF contents)
br_target  in  32  branch target
flush  in  1  exception/ertn redirect from WB; priority over br_taken
flush_target  in  32  flush target
fs_to_ds_valid  out  1  valid instruction offered to ID
fs_to_ds_pc  out  32  its PC
fs_to_ds_inst  out  32  its encoding
fs_to_ds_adef  out  1  fetch-address-misaligned exception tag
inst_sram_req  out  1  fetch request
inst_sram_addr  out  32  fetch address
inst_sram_addr_ok  in  1  request accepted when req & addr_ok
inst_sram_data_ok  in  1  response valid; responses are in order
inst_sram_rdata  in  32  response data

Behaviour:
- State registers:
  - pf_pc: next address.
  - fs_valid, fs_pc, fs_adef.
  - buf_valid, buf_inst: 1-entry hold buffer.
  - discard: one stale response owed.
  - adef_lock.
- Reset values:
  - pf_pc = RESET_PC; every other register = 0.
  - Outputs after reset: req = 0 until the first cycle after rst deasserts; fs_to_ds_valid = 0; adef = 0.
  - The memory side is reset together with this stage, so no response is owed after reset.
- cancel = flush | br_taken. redirect_target = flush ? flush_target : br_target.
- IF stage handshake:
  - readygo = fs_adef | buf_valid | (data_ok & ~discard).
  - fs_allowin = ~fs_valid | (readygo & ds_allowin).
  - fs_to_ds_valid = fs_valid & readygo & ~cancel.
- fs_to_ds_inst:
  - fs_adef: 32'h0.
  - else buf_valid: buf_inst.
  - else: inst_sram_rdata.
- Request issue:
  - inst_sram_req = fs_allowin & ~cancel & ~discard & ~adef_lock & (pf_pc[1:0] == 0).
  - inst_sram_addr = pf_pc, combinational.
  - The slave samples only on req & addr_ok. Req and addr may change in any cycle where no handshake occurs.
- Handshake cycle (req & addr_ok):
  - fs_valid <= 1; fs_pc <= pf_pc; fs_adef <= 0; pf_pc <= pf_pc + 4 (mod 2^32).
- Misaligned pf_pc with fs_allowin & ~cancel & ~adef_lock & ~discard:
  - No request is issued.
  - fs_valid <= 1; fs_adef <= 1; fs_pc <= pf_pc; adef_lock <= 1.
  - Pre-IF then stays idle until the next cancel.
- IF leaves (fs_to_ds_valid & ds_allowin) with no new entry: fs_valid <= 0; buf_valid <= 0.
- Backpressure: fs_valid & data_ok & ~discard & ~ds_allowin & ~cancel → buf_inst <= rdata, buf_valid <= 1. rdata is not required to be stable afterwards.
- Stale response: discard & data_ok → data dropped, discard <= 0. Issue stays blocked that cycle; the next request goes out one cycle later.
- Cancel (highest priority over all of the above):
  - pf_pc <= redirect_target; fs_valid <= 0; buf_valid <= 0; adef_lock <= 0.
  - If IF held an accepted request whose response has not returned (not buffered, not adef, no data_ok this cycle): discard <= 1.
  - If data_ok arrives in the cancel cycle: that data is dropped and discard stays 0.
- At most one outstanding request; discard never exceeds 1.
- Latency: an accepted request at cycle t with data_ok at t+1 (ds_allowin = 1) gives fs_to_ds_valid at t+1. Back-to-back issue is allowed because fs_allowin rises in that same cycle.

Decomposition:
- Shared header cpu_defines.vh holds:
  - RESET_PC default;
  - FS_TO_DS bus width (65: pc, inst, adef);
  - ADEF exception code.
- One natural sub-module: fetch_inst_buf, the 1-entry hold buffer with load/clear/valid.
- PC/redirect logic and the discard counter stay in the parent.

Test Plan:
1. Release rst; addr_ok = 1, data_ok 1 cycle later with rdata = 0x0280_0421 → first req addr 0x1c00_0000; fs_to_ds_valid = 1 with pc 0x1c00_0000 and inst 0x0280_0421; next req addr 0x1c00_0004.
2. ds_allowin = 0 when data_ok returns 0x1111_1111, then rdata changes to 0xdead_beef; ds_allowin = 1 three cycles later → output inst 0x1111_1111; no req while held; valid stays 1 throughout.
3. br_taken, target 0x1c00_0100, while a request is outstanding; stale data_ok arrives 2 cycles later → no fs_to_ds_valid for the old pc; next req addr 0x1c00_0100 issued only after the stale response.
4. flush (target 0x1c00_8000) and br_taken (target 0x1c00_0100) in the same cycle → next req addr 0x1c00_8000.
5. br_target 0x1c00_0102 → no req; fs_to_ds_valid = 1 with adef = 1, pc 0x1c00_0102, inst 0; req stays 0 until flush to 0x1c00_8000, then req addr 0x1c00_8000.
6. addr_ok held low for 3 cycles → req = 1 with addr stable at 0x1c00_0004; fs_to_ds_valid = 0 after the prior instruction leaves; asserting rst mid-wait → req = 0 next cycle, then restart at 0x1c00_0000.
